d_cache_plru_tree: RTL and testbench
====================================

D_CACHE_PLRU_TREE -- requirements
Module: d_cache_plru_tree

Interface
REQ-001 Parameter WAYS, default 8, associativity; power of two, 2..64.
REQ-002 Parameter SETS, default 16, number of sets; power of two, >=2.
REQ-003 Port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-005 Port touch_valid_i, input, 1, record an access (hit or fill) this cycle.
REQ-006 Port touch_set_i, input, $clog2(SETS), set of the access.
REQ-007 Port touch_way_i, input, $clog2(WAYS), way accessed.
REQ-008 Port query_valid_i, input, 1, request victim for query_set_i.
REQ-009 Port query_set_i, input, $clog2(SETS), set to choose a victim from.
REQ-010 Port inv_mask_i, input, WAYS, per-way invalid flags for query_set_i; 1 = way empty.
REQ-011 Port flush_i, input, 1, one-cycle pulse starting a clear of all tree state.
REQ-012 Port busy_o, output, 1, flush sweep in progress.
REQ-013 Port victim_valid_o, output, 1, victim_way_o valid this cycle.
REQ-014 Port victim_way_o, output, $clog2(WAYS), selected replacement way.

Function
REQ-015 Each set SHALL hold WAYS-1 tree bits in heap order: root node 0; children of node k are 2k+1 and 2k+2; the level-l node on path prefix p is (2^l-1)+p.
REQ-016 Bit convention SHALL be 0 = lower-index half, 1 = upper-index half; a stored bit records the direction of the most recent access.
REQ-017 On touch_valid_i, every node on the path of touch_way_i in touch_set_i SHALL take the corresponding way-address bit (MSB at root) at the next edge; off-path nodes and other sets are unchanged.
REQ-018 The victim SHALL be found by walking from the root and taking the inverse of each stored bit, MSB first.
REQ-019 If inv_mask_i is nonzero, the victim SHALL be the lowest-index invalid way, overriding the tree walk.
REQ-020 Latency: query_valid_i accepted in cycle t SHALL produce victim_valid_o=1 with victim_way_o in cycle t+1 (registered); victim_valid_o=0 otherwise.
REQ-021 A touch and a query to the same set in the same cycle SHALL forward: the reported victim reflects the tree after that touch.
REQ-022 The FSM SHALL have states IDLE and FLUSH; flush_i in IDLE -> FLUSH with sweep counter 0.
REQ-023 In FLUSH, one set per cycle (counter value) SHALL be cleared to all-zero; after set SETS-1 is cleared, return to IDLE; the sweep takes exactly SETS cycles.
REQ-024 busy_o SHALL be 1 exactly while in FLUSH.
REQ-025 While busy_o=1, touches and queries SHALL be ignored (no update, victim_valid_o=0 next cycle), and flush_i SHALL be ignored.
REQ-026 victim_way_o SHALL hold its last value when victim_valid_o=0.

Reset
REQ-027 Asserting rst_ni low SHALL immediately clear all tree bits of all sets, force IDLE, zero the sweep counter, and drive busy_o=0, victim_valid_o=0, victim_way_o=0.
REQ-028 Reset asserted mid-flush SHALL abort the sweep; state after release equals the post-reset state.
REQ-029 After reset, any set with inv_mask_i=0 SHALL yield victim WAYS-1.

Structure
REQ-030 Shared package cache_def SHALL carry PLRU_WAYS and PLRU_SETS defaults, derived widths, and the FSM state enum (PLRU_IDLE, PLRU_FLUSH).
REQ-031 The combinational tree walk (tree bits -> victim way) SHALL be one sub-module, d_cache_plru_walk, parametrised by WAYS.
REQ-032 Tree storage SHALL be one flop array of SETS x (WAYS-1) bits; no per-node module instances.

Verification (WAYS=8, SETS=16)
REQ-033 Reset, query set 3, inv_mask 0 -> next cycle victim_valid_o=1, victim_way_o=7.
REQ-034 Touch set 3 way 7, then query set 3 -> victim 3; then touch way 3, query -> victim 5.
REQ-035 From reset, touch ways 0..7 in order on set 5, query set 5 -> victim 0; query set 6 -> victim 7 (isolation).
REQ-036 Same-cycle touch set 2 way 7 and query set 2 from reset -> victim 3 (forwarded); query set 2 with inv_mask=8'b0010_0100 -> victim 2.
REQ-037 Touch several sets, pulse flush_i -> busy_o high exactly 16 cycles, touches/queries during sweep produce no update and victim_valid_o=0, afterwards every set returns victim 7.
REQ-038 Assert rst_ni low at sweep cycle 5 -> busy_o=0 immediately; after release all sets return victim 7 and a new flush_i is accepted.

Source files
------------

// File: rtl/d_cache_plru_tree_pkg.sv
// Shared definitions for the tree-PLRU replacement block: default geometry,
// derived widths and the flush FSM state encoding.
package cache_def;
    localparam int PLRU_WAYS  = 8;
    localparam int PLRU_SETS  = 16;
    localparam int PLRU_WAY_W = $clog2(PLRU_WAYS);
    localparam int PLRU_SET_W = $clog2(PLRU_SETS);
    localparam int PLRU_NODES = PLRU_WAYS - 1;

    typedef enum logic [0:0] {
        PLRU_IDLE  = 1'b0,
        PLRU_FLUSH = 1'b1
    } plru_state_e;
endpackage

// File: rtl/d_cache_plru_tree_if.sv
// Touch / query / flush bundle of the PLRU tree plus its victim response.
interface d_cache_plru_tree_if #(
    parameter int WAYS = cache_def::PLRU_WAYS,
    parameter int SETS = cache_def::PLRU_SETS
) ();
    import cache_def::*;

    localparam int WW = $clog2(WAYS);
    localparam int SW = $clog2(SETS);

    // Handshake: touch/query/flush are valid-only; each is taken in the cycle it
    // is high provided busy_o=0, otherwise dropped. No back-pressure exists.
    logic            touch_valid_i;
    logic [SW-1:0]   touch_set_i;
    logic [WW-1:0]   touch_way_i;
    logic            query_valid_i;
    logic [SW-1:0]   query_set_i;
    logic [WAYS-1:0] inv_mask_i;
    logic            flush_i;
    logic            busy_o;
    logic            victim_valid_o;
    logic [WW-1:0]   victim_way_o;
    plru_state_e     dbg_state_o;

    modport slave (
        input  touch_valid_i, touch_set_i, touch_way_i,
        input  query_valid_i, query_set_i, inv_mask_i, flush_i,
        output busy_o, victim_valid_o, victim_way_o, dbg_state_o
    );

    modport master (
        output touch_valid_i, touch_set_i, touch_way_i,
        output query_valid_i, query_set_i, inv_mask_i, flush_i,
        input  busy_o, victim_valid_o, victim_way_o, dbg_state_o
    );
endinterface

// File: rtl/d_cache_plru_tree_walk.sv
// Combinational tree walk: follows the inverse of each stored bit from the root
// down, producing the pseudo-least-recently-used way.
module d_cache_plru_walk #(
    parameter int WAYS = 8
) (
    input  logic [WAYS-2:0]         i_tree,
    output logic [$clog2(WAYS)-1:0] o_way
);
    localparam int WW = $clog2(WAYS);

    int   w_node;
    logic w_bit;

    always_comb begin
        o_way  = '0;
        w_node = 0;
        w_bit  = 1'b0;
        for (int l = 0; l < WW; l++) begin
            w_bit = 1'b0;
            // Constant-index mux keeps the heap lookup free of variable bit selects.
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == w_node) w_bit = i_tree[n];
            end
            o_way[WW-1-l] = ~w_bit;
            w_node        = 2 * w_node + (w_bit ? 1 : 2);
        end
    end
endmodule

// File: rtl/d_cache_plru_tree.sv
// Tree-PLRU state for a set-associative cache: per-set heap of direction bits,
// registered victim selection with same-cycle touch forwarding, and a flush sweep.
module d_cache_plru_tree
    import cache_def::*;
#(
    parameter int WAYS = PLRU_WAYS,
    parameter int SETS = PLRU_SETS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    d_cache_plru_tree_if.slave  bus
);
    localparam int WW    = $clog2(WAYS);
    localparam int SW    = $clog2(SETS);
    localparam int NODES = WAYS - 1;

    localparam logic [0:0] S_IDLE  = PLRU_IDLE;
    localparam logic [0:0] S_FLUSH = PLRU_FLUSH;

    logic [0:0]       r_state;
    logic [SW-1:0]    r_cnt;
    logic [NODES-1:0] r_tree [SETS];
    logic             r_vvalid;
    logic [WW-1:0]    r_vway;

    logic             w_busy;
    logic             w_touch;
    logic             w_query;
    logic             w_flush_start;
    logic             w_same_set;
    logic [NODES-1:0] w_touch_row;
    logic [NODES-1:0] w_query_row;
    logic [WW-1:0]    w_walk_way;
    logic [WW-1:0]    w_victim;

    assign w_busy        = (r_state == S_FLUSH);
    assign w_touch       = bus.touch_valid_i & ~w_busy;
    assign w_query       = bus.query_valid_i & ~w_busy;
    assign w_flush_start = bus.flush_i & ~w_busy;

    // Every node on the accessed way's path takes that level's way-address bit.
    always_comb begin
        w_touch_row = r_tree[bus.touch_set_i];
        for (int l = 0; l < WW; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if ((32'(bus.touch_way_i) >> (WW - l)) == p)
                    w_touch_row[(1 << l) - 1 + p] = bus.touch_way_i[WW-1-l];
            end
        end
    end

    assign w_same_set  = w_touch && (bus.touch_set_i == bus.query_set_i);
    assign w_query_row = w_same_set ? w_touch_row : r_tree[bus.query_set_i];

    d_cache_plru_walk #(.WAYS(WAYS)) u_walk (
        .i_tree (w_query_row),
        .o_way  (w_walk_way)
    );

    // An empty way always wins over the tree choice; the lowest index is taken.
    always_comb begin
        w_victim = w_walk_way;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bus.inv_mask_i[i]) w_victim = WW'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_vvalid <= 1'b0;
            r_vway   <= '0;
            for (int s = 0; s < SETS; s++) r_tree[s] <= '0;
        end else begin
            r_vvalid <= w_query;
            if (w_query) r_vway <= w_victim;
            case (r_state)
                S_IDLE: begin
                    if (w_touch) r_tree[bus.touch_set_i] <= w_touch_row;
                    if (w_flush_start) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= '0;
                    end
                end
                S_FLUSH: begin
                    r_tree[r_cnt] <= '0;
                    if (r_cnt == SW'(SETS - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o         = w_busy;
    assign bus.victim_valid_o = r_vvalid;
    assign bus.victim_way_o   = r_vway;
    assign bus.dbg_state_o    = plru_state_e'(r_state);
endmodule

// File: tb/tb_d_cache_plru_tree.sv
// Bench for d_cache_plru_tree: directed scenarios plus random traffic checked
// against a recency-timestamp model of tree-PLRU.
module tb_d_cache_plru_tree;
    import cache_def::*;

    localparam int WAYS = 8;
    localparam int SETS = 16;
    localparam int WW   = $clog2(WAYS);
    localparam int SW   = $clog2(SETS);

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    d_cache_plru_tree_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

    d_cache_plru_tree #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: last-access timestamp per (set, way); 0 = not touched since clear.
    int unsigned   stamp [SETS][WAYS];
    int unsigned   now_t;
    int            busy_left;
    int            last_way;
    logic [WW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) stamp[s][w] = 0;
    endtask

    task automatic model_reset();
        model_clear();
        busy_left = 0;
        last_way  = 0;
        exp_q.delete();
    endtask

    // Halve the candidate range each level, moving away from the most recent access.
    function automatic int model_victim(input int s, input logic [WAYS-1:0] inv);
        int lo = 0;
        int span = WAYS;
        int half;
        int best_w;
        int unsigned best;
        if (inv != '0) begin
            for (int i = 0; i < WAYS; i++) if (inv[i]) return i;
        end
        while (span > 1) begin
            half   = span / 2;
            best   = 0;
            best_w = lo;
            for (int w = lo; w < lo + span; w++) begin
                if (stamp[s][w] > best) begin
                    best   = stamp[s][w];
                    best_w = w;
                end
            end
            if (!(best != 0 && best_w >= lo + half)) lo = lo + half;
            span = half;
        end
        return lo;
    endfunction

    task automatic step(input bit tv, input int ts, input int tw, input bit qv,
                        input int qs, input logic [WAYS-1:0] inv, input bit fl);
        logic exp_valid;
        bus.touch_valid_i = tv;
        bus.touch_set_i   = ts[SW-1:0];
        bus.touch_way_i   = tw[WW-1:0];
        bus.query_valid_i = qv;
        bus.query_set_i   = qs[SW-1:0];
        bus.inv_mask_i    = inv;
        bus.flush_i       = fl;
        @(posedge clk);
        #1;
        exp_valid = qv && (busy_left == 0);
        if (busy_left == 0) begin
            if (tv) begin
                now_t++;
                stamp[ts][tw] = now_t;
            end
            if (qv) exp_q.push_back(WW'(model_victim(qs, inv)));
            if (fl) begin
                model_clear();
                busy_left = SETS;
            end
        end else begin
            busy_left--;
        end
        chk("victim_valid", {31'b0, bus.victim_valid_o}, {31'b0, exp_valid});
        if (exp_valid && exp_q.size() > 0) last_way = int'(exp_q.pop_front());
        chk("victim_way", 32'(bus.victim_way_o), last_way);
        chk("busy", {31'b0, bus.busy_o}, {31'b0, busy_left > 0});
        bus.touch_valid_i = 1'b0;
        bus.query_valid_i = 1'b0;
        bus.flush_i       = 1'b0;
        bus.inv_mask_i    = '0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic query(input int qs);
        step(0, 0, 0, 1, qs, '0, 0);
    endtask

    task automatic touch(input int ts, input int tw);
        step(1, ts, tw, 0, 0, '0, 0);
    endtask

    task automatic async_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_busy", {31'b0, bus.busy_o}, 0);
        chk("rst_vvalid", {31'b0, bus.victim_valid_o}, 0);
        chk("rst_vway", 32'(bus.victim_way_o), 0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        now_t = 0;
        model_reset();
        bus.touch_valid_i = 1'b0;
        bus.touch_set_i   = '0;
        bus.touch_way_i   = '0;
        bus.query_valid_i = 1'b0;
        bus.query_set_i   = '0;
        bus.inv_mask_i    = '0;
        bus.flush_i       = 1'b0;

        // Clock/reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, bus.busy_o}, 0);
        chk("reset_vvalid", {31'b0, bus.victim_valid_o}, 0);
        chk("reset_vway", 32'(bus.victim_way_o), 0);
        @(negedge clk);
        rst_ni = 1'b1;

        query(3);
        chk("fresh_set3", 32'(bus.victim_way_o), 7);
        touch(3, 7);
        query(3);
        chk("touch7_set3", 32'(bus.victim_way_o), 3);
        touch(3, 3);
        query(3);
        chk("touch3_set3", 32'(bus.victim_way_o), 5);
        idle();
        chk("hold_way", 32'(bus.victim_way_o), 5);

        for (int w = 0; w < WAYS; w++) touch(5, w);
        query(5);
        chk("sweep_set5", 32'(bus.victim_way_o), 0);
        query(6);
        chk("isolate_set6", 32'(bus.victim_way_o), 7);

        step(1, 2, 7, 1, 2, '0, 0);
        chk("forward_set2", 32'(bus.victim_way_o), 3);
        step(0, 0, 0, 1, 2, 8'b0010_0100, 0);
        chk("inv_mask_set2", 32'(bus.victim_way_o), 2);

        // Flush sweep with traffic that must be ignored
        touch(1, 4);
        touch(9, 2);
        step(0, 0, 0, 0, 0, '0, 1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.busy_o) break;
            step(1, $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1),
                 1, $urandom_range(0, SETS - 1), '0, $urandom_range(0, 1));
            cnt++;
        end
        chk("flush_len", cnt, SETS);
        for (int s = 0; s < SETS; s++) begin
            query(s);
            chk("post_flush", 32'(bus.victim_way_o), 7);
        end

        // Reset in the middle of a sweep
        touch(4, 1);
        step(0, 0, 0, 0, 0, '0, 1);
        repeat (5) idle();
        async_reset();
        for (int s = 0; s < SETS; s++) begin
            query(s);
            chk("post_abort", 32'(bus.victim_way_o), 7);
        end
        step(0, 0, 0, 0, 0, '0, 1);
        chk("reflush", {31'b0, bus.busy_o}, 1);
        repeat (SETS) idle();
        chk("reflush_done", {31'b0, bus.busy_o}, 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            int ts, qs;
            logic [WAYS-1:0] inv;
            ts  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2) : $urandom_range(0, SETS - 1);
            qs  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2) : $urandom_range(0, SETS - 1);
            inv = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '0;
            step($urandom_range(0, 1), ts, $urandom_range(0, WAYS - 1),
                 $urandom_range(0, 1), qs, inv, ($urandom_range(0, 149) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
